// File: rtl/search_ctrl_pkg.sv
// Shared encodings for the binary-search controller
// and the comparator blocks that answer it.
package search_ctrl_pkg;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PROPOSE = 2'd1;
   localparam logic [1:0] S_CALC    = 2'd2;
   localparam logic [1:0] S_FINISH  = 2'd3;

   localparam logic [2:0] FB_LG = 3'b100;
   localparam logic [2:0] FB_EQ = 3'b010;
   localparam logic [2:0] FB_SM = 3'b001;

   function automatic logic fb_legal(input logic [2:0] fb);
      return (fb == FB_LG) || (fb == FB_EQ) || (fb == FB_SM);
   endfunction

endpackage

// File: rtl/search_ctrl.sv
// Binary-search controller: proposes guesses to a comparator
// responder and narrows [LO,HI] from its LG/EQ/SM feedback.
module search_ctrl
   import search_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic                        START,
   output logic [WIDTH-1:0]            GUESS,
   output logic                        GUESS_VALID,
   input  logic                        FB_VALID,
   input  logic                        LG,
   input  logic                        EQ,
   input  logic                        SM,
   output logic                        DONE,
   output logic                        FOUND,
   output logic                        ERR,
   output logic [WIDTH-1:0]            RESULT,
   output logic [$clog2(WIDTH+2)-1:0]  STEPS
);

   localparam int SW = $clog2(WIDTH+2);
   localparam int BW = WIDTH + 2;

   localparam logic signed [BW-1:0] ONE    = BW'(1);
   localparam logic signed [BW-1:0] HI_MAX = {2'b00, {WIDTH{1'b1}}};

   logic [1:0]               state;
   logic signed [BW-1:0]     lo;
   logic signed [BW-1:0]     hi;
   logic signed [BW-1:0]     gx;
   logic signed [BW-1:0]     lo_nx;
   logic signed [BW-1:0]     hi_nx;
   logic [WIDTH:0]           sum;
   logic [2:0]               fb;

   // Bounds carry two extra bits so 2^WIDTH and -1 compare correctly.
   assign gx    = $signed({2'b00, GUESS});
   assign lo_nx = gx + ONE;
   assign hi_nx = gx - ONE;
   assign sum   = lo[WIDTH:0] + hi[WIDTH:0];
   assign fb    = {LG, EQ, SM};

   assign GUESS_VALID = (state == S_PROPOSE);
   assign DONE        = (state == S_FINISH);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= S_IDLE;
         lo     <= '0;
         hi     <= '0;
         GUESS  <= '0;
         FOUND  <= 1'b0;
         ERR    <= 1'b0;
         RESULT <= '0;
         STEPS  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (START) begin
                  lo    <= '0;
                  hi    <= HI_MAX;
                  STEPS <= '0;
                  FOUND <= 1'b0;
                  ERR   <= 1'b0;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               GUESS <= WIDTH'(sum >> 1);
               state <= S_PROPOSE;
            end
            S_PROPOSE: begin
               if (FB_VALID) begin
                  STEPS <= STEPS + SW'(1);
                  if (!fb_legal(fb)) begin
                     ERR   <= 1'b1;
                     state <= S_FINISH;
                  end else if (fb == FB_EQ) begin
                     FOUND  <= 1'b1;
                     RESULT <= GUESS;
                     state  <= S_FINISH;
                  end else if (fb == FB_LG) begin
                     lo    <= lo_nx;
                     state <= (lo_nx > hi) ? S_FINISH : S_CALC;
                  end else begin
                     hi    <= hi_nx;
                     state <= (lo > hi_nx) ? S_FINISH : S_CALC;
                  end
               end
            end
            S_FINISH: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
